// File: rtl/ble_rx_pkg.sv
// Shared constants, FSM encoding and helpers for the BLE receive path.
package ble_rx_pkg;

    localparam int unsigned PacketLenMaxDef = 376;
    localparam int unsigned PreambleLenDef  = 8;
    localparam int unsigned AccAddrLenDef   = 32;
    localparam int unsigned CrcLenDef       = 24;
    localparam int unsigned PduBytesMax     = 39;

    typedef enum logic [1:0] {
        StIdle,
        StCapt,
        StCheck,
        StStream
    } rx_state_e;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pdu_shift_reg.sv
// W-bit PDU buffer: parallel load, shift left by one byte per accept, and
// bit-reversed views of the top two bytes (first bit on air in the LSB).
module pdu_shift_reg
    import ble_rx_pkg::*;
#(
    parameter int unsigned W = 368
) (
    input  logic         symbol_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    output logic [7:0]   top_byte,
    output logic [7:0]   next_byte
);

    logic [W-1:0] sr_q;

    always_ff @(posedge symbol_clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift) begin
            sr_q <= sr_q << 8;
        end
    end

    assign top_byte  = bit_rev8(sr_q[W-1 -: 8]);
    assign next_byte = bit_rev8(sr_q[W-9 -: 8]);

endmodule

// File: rtl/ble_pdu_unpacker.sv
// Captures a detected packet, validates the PDU header against its length and
// streams PDU bytes over valid/ready. Define PDU_CRC_OUT_EN to also stream the CRC.
module ble_pdu_unpacker
    import ble_rx_pkg::*;
#(
    parameter int unsigned PACKET_LEN_MAX = PacketLenMaxDef,
    parameter int unsigned PREAMBLE_LEN   = PreambleLenDef,
    parameter int unsigned ACC_ADDR_LEN   = AccAddrLenDef,
    parameter int unsigned CRC_LEN        = CrcLenDef
) (
    input  logic                                   symbol_clk,
    input  logic                                   rst,
    input  logic                                   packet_detected,
    input  logic [PACKET_LEN_MAX-PREAMBLE_LEN-1:0] packet_out,
    input  logic [8:0]                             packet_len,
    output logic [7:0]                             byte_data,
    output logic                                   byte_valid,
    input  logic                                   byte_ready,
    output logic                                   byte_last,
    output logic [3:0]                             hdr_type,
    output logic [7:0]                             hdr_len,
    output logic                                   hdr_valid,
    output logic                                   len_err,
    output logic [7:0]                             drop_cnt,
    output logic [7:0]                             ovf_cnt,
    output logic                                   busy
);

    localparam int unsigned W       = PACKET_LEN_MAX - PREAMBLE_LEN;
    localparam int unsigned HdrBits = ACC_ADDR_LEN + CRC_LEN;
    localparam int unsigned RemW    = $clog2(PduBytesMax + 4);

    rx_state_e       state_q, state_d;
    logic            pd_q;
    logic [8:0]      len_q;
    logic [RemW-1:0] rem_q, rem_d;
    logic [3:0]      hdr_type_q;
    logic [7:0]      hdr_len_q, drop_cnt_q, ovf_cnt_q;
    logic            hdr_valid_q, len_err_q;

    logic            pd_rise, load, accept, hdr_err;
    logic [8:0]      n_cur, pdu_bits;
    logic [9:0]      sh;
    logic [5:0]      n_pdu;
    logic [RemW-1:0] frame_len;
    logic [W-1:0]    load_data;
    logic [7:0]      top_byte, next_byte;

    assign pd_rise = packet_detected & ~pd_q;

    // Align the first PDU bit to the buffer MSB, dropping the access address.
    always_comb begin
        n_cur = (packet_len >= 9'(PREAMBLE_LEN)) ? packet_len - 9'(PREAMBLE_LEN) : '0;
        sh    = ({1'b0, n_cur} > 10'(W)) ? '0 : 10'(W + ACC_ADDR_LEN) - {1'b0, n_cur};
    end
    assign load_data = packet_out << sh;

    always_comb begin
        pdu_bits = (len_q >= 9'(HdrBits)) ? len_q - 9'(HdrBits) : '0;
        n_pdu    = pdu_bits[8:3];
        hdr_err  = (len_q < 9'(HdrBits + 16)) || (pdu_bits[2:0] != 3'b000) ||
                   ({3'b000, n_pdu} != ({1'b0, next_byte} + 9'd2));
`ifdef PDU_CRC_OUT_EN
        frame_len = RemW'(n_pdu) + RemW'(CRC_LEN / 8);
`else
        frame_len = RemW'(n_pdu);
`endif
    end

    assign byte_valid = (state_q == StStream);
    assign accept     = byte_valid & byte_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pd_rise) state_d = StCapt;
            end
            StCapt: begin
                load    = 1'b1;
                state_d = StCheck;
            end
            StCheck: begin
                if (hdr_err) begin
                    state_d = StIdle;
                end else begin
                    state_d = StStream;
                    rem_d   = frame_len;
                end
            end
            StStream: begin
                if (accept) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == RemW'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge symbol_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            pd_q        <= 1'b0;
            len_q       <= '0;
            rem_q       <= '0;
            hdr_type_q  <= '0;
            hdr_len_q   <= '0;
            hdr_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            drop_cnt_q  <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pd_q        <= packet_detected;
            rem_q       <= rem_d;
            hdr_valid_q <= (state_q == StCheck) && !hdr_err;
            len_err_q   <= (state_q == StCheck) && hdr_err;
            if (state_q == StCapt) len_q <= n_cur;
            if (state_q == StCheck && !hdr_err) begin
                hdr_type_q <= top_byte[3:0];
                hdr_len_q  <= next_byte;
            end
            if (state_q == StCheck && hdr_err && drop_cnt_q != 8'hff) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            // A new packet while busy (including the exit cycle) is missed.
            if (pd_rise && state_q != StIdle && ovf_cnt_q != 8'hff) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
        end
    end

    pdu_shift_reg #(
        .W(W)
    ) u_sr (
        .symbol_clk(symbol_clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .shift     (accept),
        .top_byte  (top_byte),
        .next_byte (next_byte)
    );

    assign byte_data = top_byte;
    assign byte_last = byte_valid && (rem_q == RemW'(1));
    assign hdr_type  = hdr_type_q;
    assign hdr_len   = hdr_len_q;
    assign hdr_valid = hdr_valid_q;
    assign len_err   = len_err_q;
    assign drop_cnt  = drop_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ble_pdu_unpacker.sv
// Bench for ble_pdu_unpacker: builds on-air bit streams from PDU bytes and
// checks header decode, byte stream, flow control, drops, overflow and reset.
module tb_ble_pdu_unpacker;

    logic         symbol_clk;
    logic         rst;
    logic         packet_detected;
    logic [367:0] packet_out;
    logic [8:0]   packet_len;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_ready;
    logic         byte_last;
    logic [3:0]   hdr_type;
    logic [7:0]   hdr_len;
    logic         hdr_valid;
    logic         len_err;
    logic [7:0]   drop_cnt;
    logic [7:0]   ovf_cnt;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]   pdu_b[$];
    logic [31:0]  aa_v;
    logic [23:0]  crc_v;
    logic [367:0] pkt;
    logic [8:0]   plen;
    logic [3:0]   exp_type = '0;
    logic [7:0]   exp_len  = '0;
    int           exp_drop = 0;
    int           exp_ovf  = 0;

    ble_pdu_unpacker dut (
        .symbol_clk     (symbol_clk),
        .rst            (rst),
        .packet_detected(packet_detected),
        .packet_out     (packet_out),
        .packet_len     (packet_len),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .byte_last      (byte_last),
        .hdr_type       (hdr_type),
        .hdr_len        (hdr_len),
        .hdr_valid      (hdr_valid),
        .len_err        (len_err),
        .drop_cnt       (drop_cnt),
        .ovf_cnt        (ovf_cnt),
        .busy           (busy)
    );

    initial begin
        symbol_clk = 1'b0;
        forever #5 symbol_clk = ~symbol_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pdu(input logic [7:0] b0, input logic [7:0] b1, input int npay);
        pdu_b.delete();
        pdu_b.push_back(b0);
        pdu_b.push_back(b1);
        for (int i = 0; i < npay; i++) pdu_b.push_back(8'($urandom));
        aa_v  = $urandom;
        crc_v = 24'($urandom);
    endtask

    // Received bit k sits at index N-1-k; bytes go LSB first.
    task automatic build(input int extra_bits);
        bit bits[$];
        int n;
        for (int i = 0; i < 32; i++) bits.push_back(aa_v[i]);
        foreach (pdu_b[b]) for (int j = 0; j < 8; j++) bits.push_back(pdu_b[b][j]);
        for (int i = 0; i < 24; i++) bits.push_back(crc_v[i]);
        for (int i = 0; i < extra_bits; i++) bits.push_back(1'($urandom_range(0, 1)));
        n   = bits.size();
        pkt = '0;
        for (int k = 0; k < n; k++) pkt[n-1-k] = bits[k];
        plen = 9'(n + 8);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_data"}, byte_data, 0);
        chk({tag, "_byte_valid"}, byte_valid, 0);
        chk({tag, "_byte_last"}, byte_last, 0);
        chk({tag, "_hdr_type"}, hdr_type, 0);
        chk({tag, "_hdr_len"}, hdr_len, 0);
        chk({tag, "_hdr_valid"}, hdr_valid, 0);
        chk({tag, "_len_err"}, len_err, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
        chk({tag, "_ovf_cnt"}, ovf_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // mode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,1 then 1.
    task automatic run_frame(input int mode, input int ovf_at, input int abort_at);
        int         n, idx, cyc;
        bit         ok, r;
        logic [7:0] exp_b[$];
        n  = int'(plen) - 8;
        ok = (n >= 72) && ((n - 56) % 8 == 0) && ((n - 56) / 8 == 2 + int'(pdu_b[1]));
        exp_b = pdu_b;
`ifdef PDU_CRC_OUT_EN
        for (int c = 0; c < 3; c++) exp_b.push_back(crc_v[8*c +: 8]);
`endif
        @(negedge symbol_clk);
        packet_out      = pkt;
        packet_len      = plen;
        packet_detected = 1'b1;
        byte_ready      = 1'b0;
        @(negedge symbol_clk);
        packet_detected = 1'b0;
        chk("busy_capt", busy, 1);
        chk("valid_capt", byte_valid, 0);
        @(negedge symbol_clk);
        @(negedge symbol_clk);
        chk("hdr_valid", hdr_valid, ok);
        chk("len_err", len_err, !ok);
        if (ok) begin
            exp_type = pdu_b[0][3:0];
            exp_len  = pdu_b[1];
        end
        chk("hdr_type", hdr_type, exp_type);
        chk("hdr_len", hdr_len, exp_len);
        if (!ok) begin
            if (exp_drop < 255) exp_drop++;
            chk("err_no_valid", byte_valid, 0);
            chk("err_idle", busy, 0);
            @(negedge symbol_clk);
            chk("err_pulse_end", len_err, 0);
            chk("err_no_valid2", byte_valid, 0);
            chk("drop_cnt", drop_cnt, exp_drop);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < exp_b.size() && cyc < 300) begin
            if (cyc == ovf_at) begin
                packet_detected = 1'b1;
                if (exp_ovf < 255) exp_ovf++;
            end else begin
                packet_detected = 1'b0;
            end
            if (idx == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge symbol_clk);
                rst      = 1'b1;
                exp_type = '0;
                exp_len  = '0;
                exp_drop = 0;
                exp_ovf  = 0;
                return;
            end
            chk("byte_valid", byte_valid, 1);
            chk("byte_data", byte_data, exp_b[idx]);
            chk("byte_last", byte_last, idx == exp_b.size() - 1);
            chk("hdr_valid_pulse", hdr_valid, cyc == 0);
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else r = !(cyc == 1 || cyc == 2);
            byte_ready = r;
            if (r) idx++;
            cyc++;
            @(negedge symbol_clk);
        end
        packet_detected = 1'b0;
        chk("frame_bytes", idx, exp_b.size());
        chk("end_valid", byte_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_last", byte_last, 0);
        chk("ovf_cnt", ovf_cnt, exp_ovf);
        chk("drop_cnt_ok", drop_cnt, exp_drop);
    endtask

    initial begin
        rst             = 1'b1;
        packet_detected = 1'b0;
        packet_out      = '0;
        packet_len      = '0;
        byte_ready      = 1'b0;
        @(negedge symbol_clk);
        rst = 1'b0;
        @(negedge symbol_clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        set_pdu(8'h40, 8'h06, 6);
        build(0);
        chk("adv_len", plen, 128);
        run_frame(0, -1, -1);

        set_pdu(8'h40, 8'h06, 7);
        build(0);
        chk("bad_len", plen, 136);
        run_frame(0, -1, -1);

        set_pdu(8'h40, 8'h06, 6);
        build(0);
        run_frame(2, -1, -1);

        set_pdu(8'h42, 8'h06, 6);
        build(0);
        run_frame(0, 2, -1);

        set_pdu(8'h40, 8'h06, 6);
        build(0);
        run_frame(0, -1, 3);
        set_pdu(8'h43, 8'h06, 6);
        build(0);
        run_frame(0, -1, -1);

        set_pdu(8'h01, 8'h00, 0);
        build(0);
        chk("empty_len", plen, 80);
        run_frame(0, -1, -1);

        // Too short, then misaligned length.
        pdu_b.delete();
        pdu_b.push_back(8'h02);
        pdu_b.push_back(8'h00);
        build(0);
        plen = plen - 9'd8;
        run_frame(0, -1, -1);
        set_pdu(8'h05, 8'h02, 2);
        build(3);
        run_frame(0, -1, -1);

        for (int f = 0; f < 10; f++) begin
            int l;
            l = $urandom_range(0, 30);
            set_pdu(8'($urandom), 8'(l), l);
            if ($urandom_range(0, 3) == 0) pdu_b[1] = pdu_b[1] + 8'd1;
            build(0);
            run_frame(1, (f == 4) ? 1 : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
